// File: rtl/vertex_fetch.sv
// Vertex fetch: streams one object's 128-bit vertex words from BRAM into the
// transform stage, using credit-limited reads so backpressure never drops data.
module vertex_fetch #(
  parameter int ADDR_WIDTH   = 10,
  parameter int BRAM_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [ADDR_WIDTH:0]   vertex_count_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  mem_en_out,
  input  logic [127:0]          mem_data_in,
  output logic [31:0]           pos_out [3:0],
  output logic                  valid_out,
  output logic                  obj_done_out,
  input  logic                  ready_in,
  output logic                  busy_out,
  output logic                  done_out
);

  // The head register is one FIFO entry; the array holds the rest.
  localparam int MEM_DEPTH = FIFO_DEPTH - 1;
  localparam int PTR_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 2);
  localparam int VC_W      = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] base_reg;
  logic [VC_W-1:0]       count_reg;
  logic [VC_W-1:0]       issued_reg;
  logic [VC_W-1:0]       retired_reg;
  logic [CNT_W-1:0]      inflight_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic                  mem_en_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic                  mem_last_reg;

  logic [BRAM_LATENCY-1:0] dly_valid_reg, dly_valid_next;
  logic [BRAM_LATENCY-1:0] dly_last_reg, dly_last_next;

  logic                  head_valid_reg;
  logic                  head_last_reg;
  logic [127:0]          head_data_reg;

  logic [128:0]          fifo_mem [MEM_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      mem_count_reg;

  logic                  pop;
  logic                  cap;
  logic                  cap_last;
  logic                  head_free;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [CNT_W-1:0]      occupancy;
  logic                  credit_ok;
  logic                  last_xfer;

  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  issue_last;
  logic                  accept;
  logic                  zero_start;

  // Transfer, capture and FIFO movement for this cycle
  assign pop       = head_valid_reg && ready_in;
  assign cap       = dly_valid_reg[BRAM_LATENCY-1];
  assign cap_last  = dly_last_reg[BRAM_LATENCY-1];
  assign head_free = !head_valid_reg || pop;
  assign mem_rd    = head_free && (mem_count_reg != '0);
  assign mem_wr    = cap && !(head_free && (mem_count_reg == '0));
  assign occupancy = CNT_W'(head_valid_reg) + mem_count_reg;
  // A pop this cycle frees its slot in time for a read issued now.
  assign credit_ok = (occupancy + inflight_reg - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);
  assign last_xfer = pop && (retired_reg == count_reg - VC_W'(1));

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    issue_addr = base_reg + issued_reg[ADDR_WIDTH-1:0];
    issue_last = (issued_reg == count_reg - VC_W'(1));
    accept     = 1'b0;
    zero_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_in) begin
          if (vertex_count_in == '0) begin
            zero_start = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = FETCH;
            issue      = credit_ok;
            issue_addr = base_addr_in;
            issue_last = (vertex_count_in == VC_W'(1));
          end
        end
      end
      FETCH: begin
        if (issued_reg != count_reg) begin
          issue = credit_ok;
        end else begin
          state_next = DRAIN;
        end
        if (last_xfer) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      count_reg    <= '0;
      issued_reg   <= '0;
      retired_reg  <= '0;
      inflight_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      mem_en_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_last_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= inflight_reg + CNT_W'(issue) - CNT_W'(cap);
      done_reg     <= zero_start || last_xfer;
      mem_en_reg   <= issue;
      if (issue) begin
        mem_addr_reg <= issue_addr;
        mem_last_reg <= issue_last;
      end
      if (accept) begin
        base_reg    <= base_addr_in;
        count_reg   <= vertex_count_in;
        issued_reg  <= VC_W'(issue);
        retired_reg <= '0;
        busy_reg    <= 1'b1;
      end else begin
        if (issue) begin
          issued_reg <= issued_reg + VC_W'(1);
        end
        if (pop) begin
          retired_reg <= retired_reg + VC_W'(1);
        end
        if (last_xfer) begin
          busy_reg <= 1'b0;
        end
      end
    end
  end

  // Read-return delay line: bit i marks a read issued i+1 cycles before mem_en
  genvar gi;
  generate
    for (gi = 0; gi < BRAM_LATENCY; gi++) begin : g_dly
      if (gi == 0) begin : g_first
        assign dly_valid_next[gi] = mem_en_reg;
        assign dly_last_next[gi]  = mem_last_reg;
      end else begin : g_rest
        assign dly_valid_next[gi] = dly_valid_reg[gi-1];
        assign dly_last_next[gi]  = dly_last_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dly_valid_reg <= '0;
      dly_last_reg  <= '0;
    end else begin
      dly_valid_reg <= dly_valid_next;
      dly_last_reg  <= dly_last_next;
    end
  end

  // Buffer array: no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk_in) begin
    if (mem_wr) begin
      fifo_mem[wr_ptr_reg] <= {cap_last, mem_data_in};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_count_reg  <= '0;
      head_valid_reg <= 1'b0;
      head_last_reg  <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MEM_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (mem_rd) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(MEM_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      mem_count_reg <= mem_count_reg + CNT_W'(mem_wr) - CNT_W'(mem_rd);
      if (head_free) begin
        if (mem_rd) begin
          {head_last_reg, head_data_reg} <= fifo_mem[rd_ptr_reg];
          head_valid_reg <= 1'b1;
        end else if (cap) begin
          head_last_reg  <= cap_last;
          head_data_reg  <= mem_data_in;
          head_valid_reg <= 1'b1;
        end else begin
          head_valid_reg <= 1'b0;
          head_last_reg  <= 1'b0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  fifo_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
    !(mem_wr && !mem_rd && (mem_count_reg == CNT_W'(MEM_DEPTH))));
`endif

  generate
    for (gi = 0; gi < 4; gi++) begin : g_pos
      assign pos_out[gi] = head_data_reg[32*gi +: 32];
    end
  endgenerate

  assign mem_addr_out = mem_addr_reg;
  assign mem_en_out   = mem_en_reg;
  assign valid_out    = head_valid_reg;
  assign obj_done_out = head_last_reg;
  assign busy_out     = busy_reg;
  assign done_out     = done_reg;

endmodule

// File: tb/tb_vertex_fetch.sv
// Scoreboard bench for vertex_fetch: BRAM model, address/vertex queues filled at
// start, and a monitor that checks reads, transfers, stalls and credit.
module tb_vertex_fetch;
  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [AW-1:0] base_addr_in;
  logic [AW:0]   vertex_count_in;
  logic [AW-1:0] mem_addr_out;
  logic          mem_en_out;
  logic [127:0]  mem_data_in;
  logic [31:0]   pos_out [3:0];
  logic          valid_out;
  logic          obj_done_out;
  logic          ready_in;
  logic          busy_out;
  logic          done_out;

  vertex_fetch #(.ADDR_WIDTH(AW), .BRAM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .base_addr_in(base_addr_in), .vertex_count_in(vertex_count_in),
    .mem_addr_out(mem_addr_out), .mem_en_out(mem_en_out), .mem_data_in(mem_data_in),
    .pos_out(pos_out), .valid_out(valid_out), .obj_done_out(obj_done_out),
    .ready_in(ready_in), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural BRAM with fixed read latency; junk on the bus when not reading
  logic [127:0] bram [0:(1<<AW)-1];
  logic [127:0] pipe [0:LAT-1];
  always @(posedge clk_in) begin
    pipe[0] <= mem_en_out ? bram[mem_addr_out] : {$urandom, $urandom, $urandom, $urandom};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data_in = pipe[LAT-1];

  logic [128:0]  exp_q [$];
  logic [AW-1:0] addr_q [$];
  int n_checks = 0;
  int n_pass = 0;
  int en_total = 0;
  int xfer_total = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Expected stream: vertices in address order, mod 2^AW, last one flagged
  task automatic model_push(input logic [AW-1:0] b, input logic [AW:0] c);
    logic [AW-1:0] a;
    for (int i = 0; i < int'(c); i++) begin
      a = AW'((int'(b) + i) % (1 << AW));
      addr_q.push_back(a);
      exp_q.push_back({(i == int'(c) - 1), bram[a]});
    end
  endtask

  // Returns in cycle 1 relative to the start pulse in cycle 0
  task automatic start_obj(input logic [AW-1:0] b, input logic [AW:0] c);
    step();
    start_in = 1'b1;
    base_addr_in = b;
    vertex_count_in = c;
    model_push(b, c);
    step();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (done_out) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) fail_now(name, 0, 1);
    chk({name, "_drained"}, 132'(exp_q.size() + addr_q.size()), 132'(0));
  endtask

  always begin
    @(posedge clk_in);
    #1;
    case (ready_mode)
      0: ready_in = 1'b1;
      1: ready_in = 1'($urandom_range(0, 1));
      default: ready_in = 1'b0;
    endcase
  end

  // Monitor
  logic         prev_stall = 1'b0;
  logic [129:0] prev_snap;
  logic [127:0] vec;
  logic [128:0] exp_v;
  logic [AW-1:0] exp_a;
  always @(negedge clk_in) begin
    if (rst_in) begin
      en_total   = 0;
      xfer_total = 0;
      prev_stall = 1'b0;
    end else begin
      vec = {pos_out[3], pos_out[2], pos_out[1], pos_out[0]};
      if (mem_en_out) begin
        en_total++;
        if (addr_q.size() == 0) fail_now("unexpected_read", int'(mem_addr_out), -1);
        else begin
          exp_a = addr_q.pop_front();
          chk("read_addr", 132'(mem_addr_out), 132'(exp_a));
        end
      end
      if (en_total - xfer_total > DEPTH) fail_now("credit", en_total - xfer_total, DEPTH);
      if (prev_stall) chk("stall_hold", 132'({valid_out, obj_done_out, vec}), 132'(prev_snap));
      if (valid_out && ready_in) begin
        xfer_total++;
        if (exp_q.size() == 0) fail_now("unexpected_vertex", xfer_total, 0);
        else begin
          exp_v = exp_q.pop_front();
          chk("vertex", 132'({obj_done_out, vec}), 132'(exp_v));
        end
      end
      prev_stall = valid_out && !ready_in;
      prev_snap  = {valid_out, obj_done_out, vec};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) bram[i] = {$urandom, $urandom, $urandom, $urandom};
    rst_in = 1'b1;
    start_in = 1'b0;
    base_addr_in = '0;
    vertex_count_in = '0;
    ready_in = 1'b1;
    step();
    chk("reset_outputs", 132'({valid_out, mem_en_out, busy_out, done_out, obj_done_out}), 132'(0));
    step();
    rst_in = 1'b0;

    // Basic fetch with cycle-exact timing
    start_obj(10'h010, 11'd3);
    $display("basic: start base=010 count=3");
    chk("basic_c1_en_busy", 132'({mem_en_out, busy_out, valid_out}), 132'(3'b110));
    step(); step(); step();
    chk("basic_c4_valid", 132'({mem_en_out, valid_out, obj_done_out}), 132'(3'b010));
    step(); step();
    chk("basic_c6_last", 132'({valid_out, obj_done_out, busy_out, done_out}), 132'(4'b1110));
    step();
    chk("basic_c7_done", 132'({valid_out, busy_out, done_out}), 132'(3'b001));
    step();
    chk("basic_c8_quiet", 132'({busy_out, done_out}), 132'(0));
    chk("basic_drained", 132'(exp_q.size() + addr_q.size()), 132'(0));

    // Backpressure
    ready_mode = 1;
    start_obj(AW'($urandom), 11'd8);
    $display("backpressure: count=8 random ready");
    wait_done("backpressure");
    ready_mode = 0;
    step();

    // Wrap with stray starts
    start_obj(10'h3FE, 11'd4);
    $display("wrap: base=3FE count=4 with stray starts");
    start_in = 1'b1; base_addr_in = 10'h100; vertex_count_in = 11'd5;
    step();
    start_in = 1'b0;
    step();
    start_in = 1'b1; base_addr_in = 10'h200; vertex_count_in = 11'd0;
    step();
    start_in = 1'b0;
    wait_done("wrap");
    step();
    chk("wrap_idle_after", 132'({busy_out, mem_en_out}), 132'(0));

    // Zero count
    start_obj(10'h055, 11'd0);
    $display("zero: count=0");
    chk("zero_done", 132'({done_out, busy_out, mem_en_out, valid_out}), 132'(4'b1000));
    step();
    chk("zero_after", 132'({done_out, busy_out, mem_en_out, valid_out}), 132'(0));

    // Mid-object reset during stall
    ready_mode = 2;
    start_obj(10'h123, 11'd6);
    for (int k = 0; k < 8; k++) step();
    chk("stalled_valid", 132'({valid_out, busy_out}), 132'(2'b11));
    rst_in = 1'b1;
    #1;
    chk("midreset_outputs", 132'({valid_out, mem_en_out, busy_out, done_out, obj_done_out}), 132'(0));
    chk("midreset_pos", 132'({pos_out[3], pos_out[2], pos_out[1], pos_out[0]}), 132'(0));
    $display("midreset: asserted during stall");
    exp_q.delete();
    addr_q.delete();
    step();
    rst_in = 1'b0;
    ready_mode = 0;
    start_obj(10'h200, 11'd2);
    $display("after reset: count=2");
    wait_done("after_reset");

    // Back-to-back single vertex
    start_obj(10'h3FF, 11'd1);
    $display("back_to_back: count=1");
    wait_done("single");

    // Random objects
    for (int n = 0; n < 6; n++) begin
      ready_mode = (n % 2 == 0) ? 1 : 0;
      start_obj(AW'($urandom), 11'($urandom_range(1, 20)));
      $display("random object %0d: base=%h count=%0d", n, base_addr_in, vertex_count_in);
      wait_done("random");
    end
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
